instr_cache: RTL and testbench

Direct-mapped instruction cache between the CPU's `PC_OUT` and the 32-bit `INSTRUCTION` input. It returns the addressed instruction on a hit with no stall. On a miss it raises `busywait` to stall the CPU and fetches a 16-byte block from a slow instruction memory. It replaces the testbench's byte-array fetch and uses the same big-endian byte order per word.

---
 rtl/instr_cache.sv | 124 ++++++++++++
 tb/tb_instr_cache.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache: 8 blocks x 4 words over a 1 KB space.
// A hit returns the word with no stall. A miss stalls the CPU while the
// 16-byte block is fetched from instruction memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | lookup from live address; a miss latches {tag,index} for the fill
// MEM_READ | block request held on mem_address until mem_busywait drops
// UPDATE   | captured block, tag and valid bit written into the fill index
module instr_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [127:0] data_array [8];
  logic [2:0]   tag_array  [8];
  logic [7:0]   valid_bits;

  logic [5:0]   fill_reg;
  logic [127:0] fill_data;

  logic [1:0]   addr_word;
  logic [2:0]   addr_index;
  logic [2:0]   addr_tag;
  logic [2:0]   fill_index;
  logic [2:0]   fill_tag;
  logic [127:0] sel_block;
  logic         hit;

  // Address bits outside the 1 KB word-aligned space carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:10], address[1:0]};

  assign addr_word  = address[3:2];
  assign addr_index = address[6:4];
  assign addr_tag   = address[9:7];
  assign fill_tag   = fill_reg[5:3];
  assign fill_index = fill_reg[2:0];

  assign sel_block   = data_array[addr_index];
  assign hit         = valid_bits[addr_index] && (tag_array[addr_index] == addr_tag);
  assign mem_address = fill_reg;

  // Word select within the indexed block.
  always_comb begin
    instruction = sel_block[31:0];
    case (addr_word)
      2'd0: instruction = sel_block[31:0];
      2'd1: instruction = sel_block[63:32];
      2'd2: instruction = sel_block[95:64];
      2'd3: instruction = sel_block[127:96];
      default: instruction = sel_block[31:0];
    endcase
  end

  // State, fill address and valid bits; reset clears them immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      fill_reg   <= 6'd0;
      valid_bits <= 8'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && !hit) begin
        fill_reg <= {addr_tag, addr_index};
      end
      if (state == UPDATE) begin
        valid_bits[fill_index] <= 1'b1;
      end
    end
  end

  // Block storage: capture on the edge leaving MEM_READ, commit in UPDATE.
  // Validity is tracked separately, so the arrays need no reset.
  always_ff @(posedge CLK) begin
    if (state == MEM_READ && !mem_busywait) begin
      fill_data <= mem_readdata;
    end
    if (state == UPDATE) begin
      data_array[fill_index] <= fill_data;
      tag_array[fill_index]  <= fill_tag;
    end
  end

  // Next-state and handshake outputs; busywait is forced low while in reset.
  always_comb begin
    state_next = state;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    case (state)
      IDLE: begin
        busywait = !hit;
        if (!hit) state_next = MEM_READ;
      end
      MEM_READ: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) state_next = UPDATE;
      end
      UPDATE: begin
        busywait   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (RESET) busywait = 1'b0;
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a byte-array instruction memory model.
module tb_instr_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 5;
  int mem_cnt = 0;

  logic [7:0] mem_bytes [1024];

  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected word: four bytes from the flat image, lowest address in bits [31:24].
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    return {mem_bytes[base], mem_bytes[base + 10'd1], mem_bytes[base + 10'd2], mem_bytes[base + 10'd3]};
  endfunction

  // Memory: busy for lat-1 cycles of a request, then presents the block for one cycle.
  always @(negedge CLK) begin
    if (mem_read) begin
      if (mem_cnt < lat - 1) begin
        mem_busywait = 1'b1;
        mem_readdata = {4{32'hDEADBEEF}};
        mem_cnt++;
      end else begin
        mem_busywait = 1'b0;
        for (int w = 0; w < 4; w++) begin
          mem_readdata[32*w +: 32] = exp_word({22'd0, mem_address, 4'd0} + 32'(4*w));
        end
      end
    end else begin
      mem_cnt      = 0;
      mem_busywait = 1'b1;
      mem_readdata = {4{32'hDEADBEEF}};
    end
  end

  task automatic access(input logic [31:0] a, output int stall, output logic [5:0] first_ma,
                        output logic saw_rd, output logic busy0);
    stall    = 0;
    saw_rd   = 1'b0;
    first_ma = 6'h3f;
    address  = a;
    #1;
    busy0 = busywait;
    while (busywait && stall < 500) begin
      @(posedge CLK);
      #1;
      stall++;
      if (mem_read && !saw_rd) begin
        saw_rd   = 1'b1;
        first_ma = mem_address;
      end
    end
    if (stall >= 500) check("access_timeout", 32'(busywait), 32'd0);
  endtask

  int         stall;
  logic [5:0] first_ma;
  logic [5:0] last_ma;
  logic       saw_rd;
  logic       busy0;
  int         guard;

  initial begin
    for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'(i * 37 + (i >> 3) + 11);
    RESET        = 1'b1;
    address      = 32'd0;
    mem_busywait = 1'b1;
    mem_readdata = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_busywait", 32'(busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Cold miss at 0 with 5-cycle memory.
    access(32'h0, stall, first_ma, saw_rd, busy0);
    check("miss0_busy_now", 32'(busy0), 32'd1);
    check("miss0_mem_read", 32'(saw_rd), 32'd1);
    check("miss0_mem_addr", 32'(first_ma), 32'h00);
    check("miss0_stall", 32'(stall), 32'd7);
    check("miss0_instr", instruction, exp_word(32'h0));

    // Remaining words of block 0 hit.
    for (int w = 1; w < 4; w++) begin
      @(posedge CLK); #1;
      access(32'(4 * w), stall, first_ma, saw_rd, busy0);
      check("seq_hit_stall", 32'(stall), 32'd0);
      check("seq_hit_instr", instruction, exp_word(32'(4 * w)));
    end

    // Conflict eviction in index 0; 1-cycle memory on the first.
    lat = 1;
    @(posedge CLK); #1;
    access(32'h80, stall, first_ma, saw_rd, busy0);
    check("conf80_mem_addr", 32'(first_ma), 32'h08);
    check("conf80_stall", 32'(stall), 32'd3);
    check("conf80_instr", instruction, exp_word(32'h80));
    lat = 5;
    @(posedge CLK); #1;
    access(32'h0, stall, first_ma, saw_rd, busy0);
    check("conf00_mem_addr", 32'(first_ma), 32'h00);
    check("conf00_stall", 32'(stall), 32'd7);
    check("conf00_instr", instruction, exp_word(32'h0));

    // Reset while MEM_READ is in progress at 0x40.
    @(posedge CLK); #1;
    address = 32'h40;
    #1;
    check("rmid_busy_pre", 32'(busywait), 32'd1);
    @(posedge CLK); #1;
    check("rmid_mem_read_pre", 32'(mem_read), 32'd1);
    check("rmid_mem_addr_pre", 32'(mem_address), 32'h04);
    #2;
    RESET = 1'b1;
    #1;
    check("rmid_mem_read", 32'(mem_read), 32'd0);
    check("rmid_busywait", 32'(busywait), 32'd0);
    check("rmid_mem_addr", 32'(mem_address), 32'd0);
    @(posedge CLK); #1;
    check("rmid_hold_mem_read", 32'(mem_read), 32'd0);
    check("rmid_hold_busywait", 32'(busywait), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rmid_40_misses", 32'(busywait), 32'd1);
    address = 32'h0;
    #1;
    check("rmid_00_invalid", 32'(busywait), 32'd1);
    access(32'h40, stall, first_ma, saw_rd, busy0);
    check("rmid_refill_addr", 32'(first_ma), 32'h04);
    check("rmid_refill_stall", 32'(stall), 32'd7);
    check("rmid_refill_instr", instruction, exp_word(32'h40));

    // Address moves from 0x10 to 0x24 during MEM_READ.
    @(posedge CLK); #1;
    address = 32'h10;
    @(posedge CLK); #1;
    check("chg_mem_read", 32'(mem_read), 32'd1);
    check("chg_first_addr", 32'(mem_address), 32'h01);
    address = 32'h24;
    last_ma = mem_address;
    guard   = 0;
    while (busywait && guard < 500) begin
      @(posedge CLK); #1;
      guard++;
      if (mem_read) last_ma = mem_address;
    end
    if (guard >= 500) check("chg_timeout", 32'(busywait), 32'd0);
    check("chg_second_addr", 32'(last_ma), 32'h02);
    check("chg_instr", instruction, exp_word(32'h24));
    @(posedge CLK); #1;
    access(32'h10, stall, first_ma, saw_rd, busy0);
    check("chg_kept_stall", 32'(stall), 32'd0);
    check("chg_kept_instr", instruction, exp_word(32'h10));

    // Fill every index, then re-read every word with no stall.
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      access(32'(16 * i), stall, first_ma, saw_rd, busy0);
      check("fill_instr", instruction, exp_word(32'(16 * i)));
    end
    for (int i = 0; i < 32; i++) begin
      @(posedge CLK); #1;
      access(32'(4 * i), stall, first_ma, saw_rd, busy0);
      check("reread_stall", 32'(stall), 32'd0);
      check("reread_instr", instruction, exp_word(32'(4 * i)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
